// File: rtl/score_keeper_pkg.sv
// rtl/score_keeper_pkg.sv - shared types and constants for the score keeper
//
// Purpose : controller state encoding, saturated BCD score limit and default
//           point weights used by score_keeper.
// Ports   : none (package).
package score_keeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // nothing pending
    ST_COUNT = 2'd1,  // retiring one point per cycle
    ST_FULL  = 2'd2   // score pinned at BCD_MAX, draining pending
  } state_t;

  localparam logic [15:0] BCD_MAX = 16'h9999;

  localparam int DEFAULT_FLY_POINTS      = 5;
  localparam int DEFAULT_MOSQUITO_POINTS = 1;

endpackage

// File: rtl/bcd_inc4.sv
// rtl/bcd_inc4.sv - combinational 4-digit BCD increment
//
// Purpose : bcd_out = bcd_in + 1 in packed BCD, ripple digit carry.
// Ports   : bcd_in    [15:0] packed BCD operand, [15:12] = thousands
//           bcd_out   [15:0] incremented value (wraps 9999 -> 0000)
//           carry_out        high when bcd_in was 9999
module bcd_inc4 (
  input  logic [15:0] bcd_in,
  output logic [15:0] bcd_out,
  output logic        carry_out
);

  logic carry;

  always_comb begin
    carry   = 1'b1;
    bcd_out = '0;
    for (int d = 0; d < 4; d++) begin
      if (carry && (bcd_in[d*4 +: 4] == 4'd9)) begin
        bcd_out[d*4 +: 4] = 4'd0;
      end else if (carry) begin
        bcd_out[d*4 +: 4] = bcd_in[d*4 +: 4] + 4'd1;
        carry             = 1'b0;
      end else begin
        bcd_out[d*4 +: 4] = bcd_in[d*4 +: 4];
      end
    end
    carry_out = carry;
  end

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - hit scoring, BCD score counter, display latch and hit sound
//
// Purpose : converts per-target hit pulses into points, queues them in a
//           saturating pending counter and retires one point per cycle into a
//           4-digit BCD score that pins at 9999. Also latches a frame-stable
//           score copy and stretches hits into a retriggerable sound enable.
// Ports   : clk25               25 MHz clock, rising edge
//           rst                 asynchronous active-high reset
//           fly_hit      [F-1:0] one-cycle fly hit pulses
//           mosquito_hit [M-1:0] one-cycle mosquito hit pulses
//           score_clear         synchronous clear of score, display and pending
//           frame_tick          start-of-vblank pulse, loads score_disp
//           score_bcd    [15:0] live BCD score
//           score_disp   [15:0] score sampled at the last frame_tick
//           pending      [7:0]  points accepted but not yet retired
//           busy                pending != 0
//           sfx_on              hit-sound enable
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int FLY_COUNT       = 4,
  parameter int MOSQUITO_COUNT  = 12,
  parameter int FLY_POINTS      = DEFAULT_FLY_POINTS,
  parameter int MOSQUITO_POINTS = DEFAULT_MOSQUITO_POINTS,
  parameter int SFX_CYCLES      = 2500000
) (
  input  logic                      clk25,
  input  logic                      rst,
  input  logic [FLY_COUNT-1:0]      fly_hit,
  input  logic [MOSQUITO_COUNT-1:0] mosquito_hit,
  input  logic                      score_clear,
  input  logic                      frame_tick,
  output logic [15:0]               score_bcd,
  output logic [15:0]               score_disp,
  output logic [7:0]                pending,
  output logic                      busy,
  output logic                      sfx_on
);

  localparam int SFX_W = $clog2(SFX_CYCLES + 1);

  state_t           state_q, state_d;
  logic [8:0]       fly_n, mos_n, add;
  logic [9:0]       sum;
  logic             retire, any_hit;
  logic [15:0]      score_inc, score_d, disp_d;
  logic             score_carry;
  logic [7:0]       pending_d;
  logic [SFX_W-1:0] sfx_cnt, sfx_cnt_d;
  logic             sfx_d;

  bcd_inc4 u_inc (
    .bcd_in    (score_bcd),
    .bcd_out   (score_inc),
    .carry_out (score_carry)
  );

  // Hit weighting: popcount of each lane group times its point value.
  always_comb begin
    fly_n = '0;
    mos_n = '0;
    for (int i = 0; i < FLY_COUNT; i++)      fly_n = fly_n + 9'(fly_hit[i]);
    for (int i = 0; i < MOSQUITO_COUNT; i++) mos_n = mos_n + 9'(mosquito_hit[i]);
    add     = fly_n * 9'(FLY_POINTS) + mos_n * 9'(MOSQUITO_POINTS);
    any_hit = (|fly_hit) | (|mosquito_hit);
  end

  // Controller next state and datapath. The state register always reflects
  // the registered pending/score pair, so it is computed from their next values.
  always_comb begin
    state_d   = ST_IDLE;
    retire    = (state_q == ST_COUNT);
    sum       = {2'b00, pending} + {1'b0, add} - {9'b0, retire};
    pending_d = (sum > 10'd255) ? 8'hFF : sum[7:0];
    score_d   = score_bcd;
    disp_d    = score_disp;

    // carry_out only rises at 9999, which COUNT never increments
    if (retire && !score_carry) score_d = score_inc;
    if (score_bcd == BCD_MAX)   pending_d = 8'd0;
    if (frame_tick)             disp_d = score_bcd;

    if (score_clear) begin
      pending_d = 8'd0;
      score_d   = 16'h0000;
      disp_d    = 16'h0000;
    end

    if (pending_d == 8'd0)         state_d = ST_IDLE;
    else if (score_d == BCD_MAX)   state_d = ST_FULL;
    else                           state_d = ST_COUNT;

    // Sound stretcher: reload on any hit, count down to zero otherwise.
    sfx_cnt_d = '0;
    sfx_d     = 1'b0;
    if (any_hit) begin
      sfx_cnt_d = SFX_W'(SFX_CYCLES - 1);
      sfx_d     = 1'b1;
    end else if (sfx_cnt != '0) begin
      sfx_cnt_d = sfx_cnt - SFX_W'(1);
      sfx_d     = 1'b1;
    end
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      score_bcd  <= 16'h0000;
      score_disp <= 16'h0000;
      pending    <= 8'd0;
      busy       <= 1'b0;
      sfx_cnt    <= '0;
      sfx_on     <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_bcd  <= score_d;
      score_disp <= disp_d;
      pending    <= pending_d;
      busy       <= (pending_d != 8'd0);
      sfx_cnt    <= sfx_cnt_d;
      sfx_on     <= sfx_d;
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - directed self-checking bench for score_keeper
module tb_score_keeper;

  logic        clk25 = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  fly_hit = '0;
  logic [11:0] mosquito_hit = '0;
  logic        score_clear = 1'b0;
  logic        frame_tick = 1'b0;
  logic [15:0] score_bcd, score_disp;
  logic [7:0]  pending;
  logic        busy, sfx_on;

  int checks = 0;
  int errors = 0;

  score_keeper #(
    .FLY_COUNT       (4),
    .MOSQUITO_COUNT  (12),
    .FLY_POINTS      (5),
    .MOSQUITO_POINTS (1),
    .SFX_CYCLES      (16)
  ) dut (
    .clk25        (clk25),
    .rst          (rst),
    .fly_hit      (fly_hit),
    .mosquito_hit (mosquito_hit),
    .score_clear  (score_clear),
    .frame_tick   (frame_tick),
    .score_bcd    (score_bcd),
    .score_disp   (score_disp),
    .pending      (pending),
    .busy         (busy),
    .sfx_on       (sfx_on)
  );

  always #5 clk25 = ~clk25;

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  task automatic do_clear();
    score_clear = 1'b1;
    tick();
    score_clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({score_bcd, score_disp, pending, busy, sfx_on} !== 42'd0) begin
      $display("FAIL reset_init: got score=%h disp=%h pend=%0d busy=%b sfx=%b, expected all 0",
               score_bcd, score_disp, pending, busy, sfx_on);
      errors++;
    end
    rst = 1'b0;
    fly_hit = 4'b0001;
    tick();
    fly_hit = 4'b0000;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({score_bcd, score_disp, pending, busy, sfx_on} !== 42'd0) begin
      $display("FAIL reset_async: got score=%h disp=%h pend=%0d busy=%b sfx=%b, expected all 0",
               score_bcd, score_disp, pending, busy, sfx_on);
      errors++;
    end
    rst = 1'b0;
    fly_hit = 4'b0001;
    tick();
    fly_hit = 4'b0000;
    checks++;
    if (pending !== 8'd5 || score_bcd !== 16'h0000) begin
      $display("FAIL reset_first_hit: got pend=%0d score=%h, expected pend=5 score=0000", pending, score_bcd);
      errors++;
    end
    repeat (5) tick();
    checks++;
    if (score_bcd !== 16'h0005 || busy !== 1'b0) begin
      $display("FAIL reset_first_score: got score=%h busy=%b, expected 0005 busy=0", score_bcd, busy);
      errors++;
    end
  endtask

  task automatic test_multi_hit();
    do_clear();
    checks++;
    if (score_bcd !== 16'h0000 || score_disp !== 16'h0000) begin
      $display("FAIL multi_clear: got score=%h disp=%h, expected 0000 0000", score_bcd, score_disp);
      errors++;
    end
    fly_hit = 4'b0011;
    mosquito_hit = 12'h007;
    tick();
    fly_hit = '0;
    mosquito_hit = '0;
    checks++;
    if (pending !== 8'd13 || busy !== 1'b1) begin
      $display("FAIL multi_pending: got pend=%0d busy=%b, expected 13 busy=1", pending, busy);
      errors++;
    end
    repeat (12) tick();
    checks++;
    if (score_bcd !== 16'h0012 || pending !== 8'd1) begin
      $display("FAIL multi_t13: got score=%h pend=%0d, expected 0012 pend=1", score_bcd, pending);
      errors++;
    end
    tick();
    checks++;
    if (score_bcd !== 16'h0013 || pending !== 8'd0 || busy !== 1'b0) begin
      $display("FAIL multi_t14: got score=%h pend=%0d busy=%b, expected 0013 0 0", score_bcd, pending, busy);
      errors++;
    end
    checks++;
    if (score_disp !== 16'h0000) begin
      $display("FAIL multi_disp_hold: got disp=%h, expected 0000", score_disp);
      errors++;
    end
  endtask

  task automatic test_display();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    checks++;
    if (score_disp !== 16'h0013) begin
      $display("FAIL disp_load: got disp=%h, expected 0013", score_disp);
      errors++;
    end
    score_clear = 1'b1;
    fly_hit = 4'b0001;
    tick();
    score_clear = 1'b0;
    fly_hit = 4'b0000;
    checks++;
    if (pending !== 8'd0 || score_bcd !== 16'h0000 || score_disp !== 16'h0000) begin
      $display("FAIL clear_discard: got pend=%0d score=%h disp=%h, expected 0 0000 0000",
               pending, score_bcd, score_disp);
      errors++;
    end
    fly_hit = 4'b0011;
    tick();
    fly_hit = 4'b0000;
    repeat (5) tick();
    checks++;
    if (score_disp !== 16'h0000 || score_bcd !== 16'h0005) begin
      $display("FAIL disp_midframe: got disp=%h score=%h, expected 0000 0005", score_disp, score_bcd);
      errors++;
    end
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    checks++;
    if (score_disp !== 16'h0005 || score_bcd !== 16'h0006) begin
      $display("FAIL disp_tick: got disp=%h score=%h, expected 0005 0006", score_disp, score_bcd);
      errors++;
    end
    repeat (4) tick();
    checks++;
    if (score_disp !== 16'h0005 || score_bcd !== 16'h0010) begin
      $display("FAIL disp_hold: got disp=%h score=%h, expected 0005 0010", score_disp, score_bcd);
      errors++;
    end
  endtask

  task automatic test_carry_saturation();
    do_clear();
    for (int i = 0; i < 199; i++) begin
      mosquito_hit = 12'h001;
      tick();
    end
    mosquito_hit = '0;
    tick();
    checks++;
    if (score_bcd !== 16'h0199 || pending !== 8'd0) begin
      $display("FAIL carry_0199: got score=%h pend=%0d, expected 0199 0", score_bcd, pending);
      errors++;
    end
    mosquito_hit = 12'h800;
    tick();
    mosquito_hit = '0;
    tick();
    checks++;
    if (score_bcd !== 16'h0200) begin
      $display("FAIL carry_0200: got score=%h, expected 0200", score_bcd);
      errors++;
    end
    for (int i = 0; i < 9797; i++) begin
      mosquito_hit = 12'h010;
      tick();
    end
    mosquito_hit = '0;
    tick();
    checks++;
    if (score_bcd !== 16'h9997 || busy !== 1'b0) begin
      $display("FAIL sat_preload: got score=%h busy=%b, expected 9997 0", score_bcd, busy);
      errors++;
    end
    fly_hit = 4'b0100;
    tick();
    fly_hit = 4'b0000;
    checks++;
    if (pending !== 8'd5 || score_bcd !== 16'h9997) begin
      $display("FAIL sat_hit: got pend=%0d score=%h, expected 5 9997", pending, score_bcd);
      errors++;
    end
    tick();
    tick();
    checks++;
    if (score_bcd !== 16'h9999 || pending !== 8'd3 || busy !== 1'b1) begin
      $display("FAIL sat_reach: got score=%h pend=%0d busy=%b, expected 9999 3 1", score_bcd, pending, busy);
      errors++;
    end
    tick();
    checks++;
    if (score_bcd !== 16'h9999 || pending !== 8'd0 || busy !== 1'b0) begin
      $display("FAIL sat_drain: got score=%h pend=%0d busy=%b, expected 9999 0 0", score_bcd, pending, busy);
      errors++;
    end
    repeat (3) tick();
    checks++;
    if (score_bcd !== 16'h9999) begin
      $display("FAIL sat_hold: got score=%h, expected 9999", score_bcd);
      errors++;
    end
  endtask

  task automatic test_pending_saturation();
    int exp_pend;
    do_clear();
    exp_pend = 0;
    for (int i = 0; i < 60; i++) begin
      fly_hit = 4'hF;
      tick();
      exp_pend = exp_pend + 20 - ((exp_pend != 0) ? 1 : 0);
      if (exp_pend > 255) exp_pend = 255;
      checks++;
      if (pending !== 8'(exp_pend)) begin
        $display("FAIL pend_sat_cycle%0d: got pend=%0d, expected %0d", i, pending, exp_pend);
        errors++;
      end
    end
    checks++;
    if (pending !== 8'd255 || score_bcd !== 16'h0059) begin
      $display("FAIL pend_sat_final: got pend=%0d score=%h, expected 255 0059", pending, score_bcd);
      errors++;
    end
    score_clear = 1'b1;
    tick();
    score_clear = 1'b0;
    fly_hit = 4'h0;
    checks++;
    if (pending !== 8'd0 || score_bcd !== 16'h0000 || sfx_on !== 1'b1) begin
      $display("FAIL clear_busy: got pend=%0d score=%h sfx=%b, expected 0 0000 1", pending, score_bcd, sfx_on);
      errors++;
    end
  endtask

  task automatic test_sfx();
    repeat (20) tick();
    checks++;
    if (sfx_on !== 1'b0) begin
      $display("FAIL sfx_idle: got sfx=%b, expected 0", sfx_on);
      errors++;
    end
    mosquito_hit = 12'h001;
    tick();
    mosquito_hit = '0;
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (sfx_on !== (k <= 15)) begin
        $display("FAIL sfx_single_t%0d: got sfx=%b, expected %b", k + 1, sfx_on, (k <= 15));
        errors++;
      end
      tick();
    end
    mosquito_hit = 12'h002;
    tick();
    mosquito_hit = '0;
    for (int k = 0; k < 30; k++) begin
      checks++;
      if (sfx_on !== (k <= 25)) begin
        $display("FAIL sfx_retrig_t%0d: got sfx=%b, expected %b", k + 1, sfx_on, (k <= 25));
        errors++;
      end
      mosquito_hit = (k == 9) ? 12'h004 : 12'h000;
      tick();
    end
    mosquito_hit = '0;
  endtask

  initial begin
    test_reset();
    test_multi_hit();
    test_display();
    test_carry_saturation();
    test_pending_saturation();
    test_sfx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
